// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: transmit-scheduler state
// encodings and the byte width used when slicing words into UART bytes.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        TXS_IDLE      = 3'd0,
        TXS_SEND      = 3'd1,
        TXS_WAIT_DONE = 3'd2,
        TXS_WAIT_IDLE = 3'd3,
        TXS_FINISH    = 3'd4
    } txs_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping
// around, found with a priority encoder over a doubled request vector.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   idx
);

    logic [N_REQ-1:0]   mask_s;
    logic [2*N_REQ-1:0] dbl_s;

    // Lower copy keeps only bits >= ptr; the upper copy supplies the wrap-around.
    always_comb begin
        mask_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) >= ptr) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
        dbl_s = {req, req & mask_s};
        valid = |req;
        idx   = {PTR_W{1'b0}};
        for (int j = 2*N_REQ-1; j >= 0; j--) begin
            if (dbl_s[j]) begin
                if (j >= N_REQ) begin
                    idx = PTR_W'(j - N_REQ);
                end else begin
                    idx = PTR_W'(j);
                end
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ requesters: round-robin grant,
// then LSB-first byte serialisation paced by the transmitter's finished_tx level.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8,
    parameter int CNT_W  = $clog2(BYTES) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ*CNT_W-1:0]  req_nbytes,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    txs_state_e         state_r, state_n_s;
    logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_n_s;
    logic [PTR_W-1:0]   owner_r, owner_n_s;
    logic [DATA_W-1:0]  word_r, word_n_s;
    logic [CNT_W-1:0]   nb_r, nb_n_s;
    logic [CNT_W-1:0]   byte_idx_r, byte_idx_n_s;

    logic [N_REQ-1:0]   gnt_r, done_r;
    logic               busy_r, tx_start_r;
    logic [7:0]         tx_data_r;

    logic               pick_valid_s;
    logic [PTR_W-1:0]   pick_idx_s;
    logic [DATA_W-1:0]  data_arr_s [N_REQ];
    logic [CNT_W-1:0]   nb_arr_s   [N_REQ];
    logic [CNT_W-1:0]   nb_clamp_s;
    logic [N_REQ-1:0]   owner_oh_s;
    logic [7:0]         tx_byte_s;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign data_arr_s[g] = req_data[g*DATA_W +: DATA_W];
        assign nb_arr_s[g]   = req_nbytes[g*CNT_W +: CNT_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Next-state logic; registers hold their value unless a state updates them.
    always_comb begin
        state_n_s    = state_r;
        rr_ptr_n_s   = rr_ptr_r;
        owner_n_s    = owner_r;
        word_n_s     = word_r;
        nb_n_s       = nb_r;
        byte_idx_n_s = byte_idx_r;
        if (nb_arr_s[pick_idx_s] > CNT_W'(BYTES)) begin
            nb_clamp_s = CNT_W'(BYTES);
        end else begin
            nb_clamp_s = nb_arr_s[pick_idx_s];
        end
        case (state_r)
            TXS_IDLE: begin
                if (pick_valid_s) begin
                    owner_n_s    = pick_idx_s;
                    word_n_s     = data_arr_s[pick_idx_s];
                    nb_n_s       = nb_clamp_s;
                    byte_idx_n_s = {CNT_W{1'b0}};
                    if (nb_clamp_s == {CNT_W{1'b0}}) begin
                        state_n_s = TXS_FINISH;
                    end else begin
                        state_n_s = TXS_SEND;
                    end
                end else begin
                    state_n_s = TXS_IDLE;
                end
            end
            TXS_SEND: begin
                state_n_s = TXS_WAIT_DONE;
            end
            TXS_WAIT_DONE: begin
                if (tx_done) begin
                    state_n_s = TXS_WAIT_IDLE;
                end else begin
                    state_n_s = TXS_WAIT_DONE;
                end
            end
            TXS_WAIT_IDLE: begin
                // tx_done low means the UART FSM is back in IDLE and can take a byte
                if (!tx_done) begin
                    if (byte_idx_r == nb_r - CNT_W'(1)) begin
                        state_n_s = TXS_FINISH;
                    end else begin
                        byte_idx_n_s = byte_idx_r + CNT_W'(1);
                        state_n_s    = TXS_SEND;
                    end
                end else begin
                    state_n_s = TXS_WAIT_IDLE;
                end
            end
            TXS_FINISH: begin
                if (owner_r == PTR_W'(N_REQ - 1)) begin
                    rr_ptr_n_s = {PTR_W{1'b0}};
                end else begin
                    rr_ptr_n_s = owner_r + PTR_W'(1);
                end
                state_n_s = TXS_IDLE;
            end
            default: begin
                state_n_s = TXS_IDLE;
            end
        endcase
    end

    assign owner_oh_s = N_REQ'(1'b1) << owner_n_s;
    assign tx_byte_s  = BYTE_W'(word_n_s >> {byte_idx_n_s, 3'b000});

    // State, datapath and outputs; outputs are registered from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= TXS_IDLE;
            rr_ptr_r   <= {PTR_W{1'b0}};
            owner_r    <= {PTR_W{1'b0}};
            word_r     <= {DATA_W{1'b0}};
            nb_r       <= {CNT_W{1'b0}};
            byte_idx_r <= {CNT_W{1'b0}};
            gnt_r      <= {N_REQ{1'b0}};
            done_r     <= {N_REQ{1'b0}};
            busy_r     <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else begin
            state_r    <= state_n_s;
            rr_ptr_r   <= rr_ptr_n_s;
            owner_r    <= owner_n_s;
            word_r     <= word_n_s;
            nb_r       <= nb_n_s;
            byte_idx_r <= byte_idx_n_s;
            gnt_r      <= (state_n_s != TXS_IDLE)   ? owner_oh_s : {N_REQ{1'b0}};
            done_r     <= (state_n_s == TXS_FINISH) ? owner_oh_s : {N_REQ{1'b0}};
            busy_r     <= (state_n_s != TXS_IDLE);
            tx_start_r <= (state_n_s == TXS_SEND);
            if (state_n_s == TXS_SEND) begin
                tx_data_r <= tx_byte_s;
            end else begin
                tx_data_r <= tx_data_r;
            end
        end
    end

    assign gnt      = gnt_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed plus randomized bench for uart_tx_scheduler with a behavioural
// UART model and a round-robin reference model built from queues.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int CW  = 3;
    localparam int PER = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N*CW-1:0] req_nbytes;
    logic [N-1:0]    gnt, done;
    logic            busy, tx_start;
    logic [7:0]      tx_data;
    logic            tx_done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tx_q[$];
    logic [3:0] grant_q[$];
    logic [3:0] done_q[$];
    time        start_t_q[$];
    time        fall_t_q[$];
    int         start_cnt;
    logic [3:0] prev_gnt;
    bit         auto_clear;
    int         stop_len;
    bit         model_busy;

    uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_nbytes (req_nbytes),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

    always #(PER/2) clk = ~clk;

    // UART transmitter model: 2 cycles after transmit, finished_tx high for stop_len cycles.
    initial begin
        tx_done    = 1'b0;
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                model_busy = 1'b1;
                tx_q.push_back(tx_data);
                repeat (2) @(negedge clk);
                tx_done = 1'b1;
                repeat (stop_len) @(negedge clk);
                tx_done = 1'b0;
                fall_t_q.push_back($time);
                model_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (tx_start === 1'b1) begin
            start_cnt++;
            start_t_q.push_back($time);
        end
        if (done !== 4'b0000) begin
            done_q.push_back(done);
            if (auto_clear) req = req & ~done;
        end
        if (gnt !== 4'b0000 && prev_gnt === 4'b0000) grant_q.push_back(gnt);
        prev_gnt = gnt;
        chk("gnt_vs_busy", {62'd0, (gnt != 4'b0000), $onehot0(gnt)}, {62'd0, busy, 1'b1});
    endtask

    task automatic clear_q();
        tx_q.delete(); grant_q.delete(); done_q.delete();
        start_t_q.delete(); fall_t_q.delete();
        start_cnt = 0;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (done_q.size() < n) chk("timeout_done", 64'(done_q.size()), 64'(n));
    endtask

    task automatic wait_model_idle();
        int k = 0;
        while ((model_busy || tx_done) && k < 1000) begin
            tick();
            k++;
        end
        if (model_busy) chk("timeout_model", 64'(model_busy), 64'd0);
        tick();
    endtask

    task automatic set_req(input int i, input logic [31:0] w, input logic [2:0] nb);
        req_data[i*DW +: DW] = w;
        req_nbytes[i*CW +: CW] = nb;
        req[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] words [N];
        logic [2:0]  nbs   [N];
        logic [7:0]  exp_bytes[$];
        logic [3:0]  exp_grant[$];
        logic [3:0]  pending, mask;
        int          ptr, exp_ptr, c, nsend;

        rst = 1'b1; req = '0; req_data = '0; req_nbytes = '0;
        auto_clear = 1'b1; stop_len = 5; prev_gnt = 4'b0000; start_cnt = 0;

        // reset state
        tick(); tick();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tx_start", 64'(tx_start), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'h00);
        rst = 1'b0;
        tick();
        clear_q();

        // single requester, 4 bytes, first byte one cycle after sampling
        set_req(0, 32'h44332211, 3'd4);
        tick();
        chk("single_lat_gnt", 64'(gnt), 64'h1);
        chk("single_lat_start", 64'(tx_start), 64'h1);
        chk("single_lat_data", 64'(tx_data), 64'h11);
        wait_dones(1, 500);
        wait_model_idle();
        chk("single_nstart", 64'(start_cnt), 64'd4);
        chk("single_nbytes", 64'(tx_q.size()), 64'd4);
        for (int b = 0; b < 4 && b < tx_q.size(); b++)
            chk("single_byte", 64'(tx_q[b]), 64'(8'h11 * (b + 1)));
        chk("single_ndone", 64'(done_q.size()), 64'd1);
        chk("single_ngrant", 64'(grant_q.size()), 64'd1);
        if (grant_q.size() > 0) chk("single_gnt", 64'(grant_q[0]), 64'h1);

        // fairness: all hold req, expect 0,1,2,3,0
        do_reset();
        clear_q();
        auto_clear = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'hA0 + i, 3'd1);
        begin
            int k = 0;
            while (done_q.size() < 5 && k < 1000) begin
                tick();
                k++;
            end
            req = '0;
            chk("fair_ndone", 64'(done_q.size()), 64'd5);
        end
        auto_clear = 1'b1;
        wait_model_idle();
        chk("fair_ngrant", 64'(grant_q.size()), 64'd5);
        for (int k = 0; k < 5 && k < grant_q.size() && k < done_q.size(); k++) begin
            chk("fair_order", 64'(grant_q[k]), 64'(4'b0001 << (k % 4)));
            chk("fair_done", 64'(done_q[k]), 64'(grant_q[k]));
        end

        // rotation: serve 2, then 1 and 3 together -> 3 before 1
        clear_q();
        set_req(2, 32'h5555_00C2, 3'd1);
        wait_dones(1, 500);
        wait_model_idle();
        set_req(1, 32'h0000_00B1, 3'd1);
        set_req(3, 32'h0000_00B3, 3'd1);
        wait_dones(3, 1000);
        wait_model_idle();
        chk("rot_ngrant", 64'(grant_q.size()), 64'd3);
        if (grant_q.size() == 3) begin
            chk("rot_first", 64'(grant_q[1]), 64'b1000);
            chk("rot_second", 64'(grant_q[2]), 64'b0010);
        end

        // zero byte count: done in the cycle after the sampling edge, no byte
        clear_q();
        set_req(0, 32'hDEADBEEF, 3'd0);
        tick();
        chk("zero_done", 64'(done), 64'b0001);
        chk("zero_gnt", 64'(gnt), 64'b0001);
        tick();
        chk("zero_gnt_drop", 64'(gnt), 64'd0);
        repeat (5) tick();
        chk("zero_nstart", 64'(start_cnt), 64'd0);

        // over-range byte count clamps to 4
        clear_q();
        set_req(2, 32'h9A8B7C6D, 3'd7);
        wait_dones(1, 500);
        wait_model_idle();
        chk("clamp_nstart", 64'(start_cnt), 64'd4);
        chk("clamp_nbytes", 64'(tx_q.size()), 64'd4);
        if (tx_q.size() == 4) chk("clamp_last", 64'(tx_q[3]), 64'h9A);

        // long STOP bit: next transmit exactly one cycle after finished_tx falls
        clear_q();
        stop_len = 200;
        set_req(1, 32'h0000_7F3E, 3'd2);
        wait_dones(1, 2000);
        wait_model_idle();
        chk("long_nstart", 64'(start_cnt), 64'd2);
        if (start_t_q.size() == 2 && fall_t_q.size() >= 1)
            chk("long_gap", 64'(start_t_q[1] - fall_t_q[0]), 64'(PER));
        else
            chk("long_times", 64'(start_t_q.size()), 64'd2);
        stop_len = 5;

        // reset during WAIT_DONE of byte 2 (rr_ptr is 2 here if not cleared)
        clear_q();
        set_req(3, 32'hA1B2C3D4, 3'd4);
        begin
            int k = 0;
            while (start_cnt < 2 && k < 300) begin
                tick();
                k++;
            end
            chk("mid_reach_byte2", 64'(start_cnt), 64'd2);
        end
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        chk("mid_gnt", 64'(gnt), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_tx_start", 64'(tx_start), 64'd0);
        chk("mid_tx_data", 64'(tx_data), 64'h00);
        tick();
        rst = 1'b0;
        wait_model_idle();
        chk("mid_no_done", 64'(done_q.size()), 64'd0);
        clear_q();
        set_req(1, 32'h0000_6655, 3'd2);
        set_req(3, 32'h0000_8877, 3'd2);
        wait_dones(2, 1000);
        wait_model_idle();
        if (grant_q.size() == 2) begin
            chk("mid_restart_gnt", 64'(grant_q[0]), 64'b0010);
            chk("mid_restart_gnt2", 64'(grant_q[1]), 64'b1000);
        end else begin
            chk("mid_restart_ngrant", 64'(grant_q.size()), 64'd2);
        end
        if (tx_q.size() > 0) chk("mid_restart_byte0", 64'(tx_q[0]), 64'h55);

        // randomized rounds against the reference model
        do_reset();
        exp_ptr = 0;
        for (int r = 0; r < 8; r++) begin
            clear_q();
            exp_bytes.delete();
            exp_grant.delete();
            mask = 4'($urandom_range(1, 15));
            stop_len = $urandom_range(1, 6);
            for (int i = 0; i < N; i++) begin
                words[i] = $urandom;
                nbs[i]   = 3'($urandom_range(0, 7));
            end
            pending = mask;
            ptr = exp_ptr;
            while (pending != 4'b0000) begin
                c = ptr;
                for (int k = 0; k < N; k++) begin
                    if (pending[(ptr + k) % N]) begin
                        c = (ptr + k) % N;
                        break;
                    end
                end
                exp_grant.push_back(4'b0001 << c);
                nsend = (nbs[c] > 3'd4) ? 4 : int'(nbs[c]);
                for (int b = 0; b < nsend; b++) exp_bytes.push_back(8'(words[c] >> (8 * b)));
                pending[c] = 1'b0;
                ptr = (c + 1) % N;
            end
            exp_ptr = ptr;
            for (int i = 0; i < N; i++) if (mask[i]) set_req(i, words[i], nbs[i]);
            wait_dones(exp_grant.size(), 4000);
            wait_model_idle();
            chk("rnd_ngrant", 64'(grant_q.size()), 64'(exp_grant.size()));
            chk("rnd_nbytes", 64'(tx_q.size()), 64'(exp_bytes.size()));
            for (int k = 0; k < exp_grant.size() && k < grant_q.size() && k < done_q.size(); k++) begin
                chk("rnd_grant", 64'(grant_q[k]), 64'(exp_grant[k]));
                chk("rnd_done", 64'(done_q[k]), 64'(exp_grant[k]));
            end
            for (int k = 0; k < exp_bytes.size() && k < tx_q.size(); k++)
                chk("rnd_byte", 64'(tx_q[k]), 64'(exp_bytes[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
